// File: rtl/pali_pkg.sv
// Palindrome generator shared types.
// FSM states and half-word width helpers.
package pali_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the free upper half of a W-bit palindrome.
  function automatic int half_w(input int w);
    return (w + 1) / 2;
  endfunction

  // Number of low bits that mirror the upper half.
  function automatic int mirror_w(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/pali_mirror.sv
// Palindrome word builder.
// Places h in the top bits and reflects it into the low bits.
module pali_mirror
  import pali_pkg::*;
#(
  parameter  int W = 3,
  localparam int H = half_w(W)
) (
  input  logic [H-1:0] h,
  output logic [W-1:0] word
);

  localparam int L = mirror_w(W);

  // Upper half is h; bit i copies bit W-1-i, which is h[H-1-i].
  always_comb begin
    word = '0;
    word[W-1 -: H] = h;
    for (int i = 0; i < L; i++) begin
      word[i] = h[H-1-i];
    end
  end

endmodule

// File: rtl/pali_gen.sv
// Palindrome generator with valid/ready output.
// Enumerates all W-bit palindromes or emits one from a seed.
module pali_gen
  import pali_pkg::*;
#(
  parameter  int W = 3,
  localparam int H = half_w(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [H-1:0] seed,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic [H:0]   count
);

  state_e       state_q, state_d;
  logic [H-1:0] h_q, h_d;
  logic         mode_q, mode_d;
  logic [H:0]   count_q, count_d;
  logic         xfer;
  logic         last;
  logic [W-1:0] word;

  pali_mirror #(
    .W (W)
  ) u_mirror (
    .h    (h_q),
    .word (word)
  );

  assign xfer = out_valid & out_ready;
  // Seeded runs end after one word; enumeration stops at all-ones.
  assign last = mode_q | (&h_q);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  // Next-state: accept start in IDLE, step h on each transfer.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    mode_d  = mode_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          count_d = '0;
          h_d     = mode ? seed : '0;
        end
      end
      RUN: begin
        if (xfer) begin
          count_d = count_q + 1'b1;
          if (last) begin
            state_d = DONE;
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    out_valid = (state_q == RUN);
    out_data  = out_valid ? word : '0;
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    count     = count_q;
  end

endmodule
